// File: rtl/uart_alu_host.sv
// Host-side initiator for the UART ALU link: sends operand A, operand B and opcode as
// three 8N1 frames, then waits for one reply frame (or a timeout) and pulses done.
module uart_alu_host #(
  parameter int DBIT          = 8,
  parameter int SB_TICK       = 16,
  parameter int TIMEOUT_TICKS = 65535
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            start,
  input  logic [DBIT-1:0] a,
  input  logic [DBIT-1:0] b,
  input  logic [5:0]      op,
  input  logic            rx,
  output logic            tx,
  output logic [DBIT-1:0] result,
  output logic            busy,
  output logic            done,
  output logic            timeout_err,
  output logic            frame_err
);

  localparam int CW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int BW = (DBIT > 2) ? $clog2(DBIT) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } top_state_e;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

  top_state_e      st_q, st_d;
  ser_state_e      tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [DBIT-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]   tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DBIT-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic            tx_q, tx_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [TW-1:0]   to_q, to_d;
  logic [DBIT-1:0] result_q, result_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            terr_q, terr_d, ferr_q, ferr_d;
  logic [DBIT-1:0] cur_byte_s, nxt_byte_s;
  logic            tx_frame_end_s, rx_frame_done_s, rx_fall_s;

  function automatic logic [DBIT-1:0] sel_byte(input logic [1:0] i, input logic [DBIT-1:0] x,
                                               input logic [DBIT-1:0] y, input logic [DBIT-1:0] z);
    case (i)
      2'd0:    sel_byte = x;
      2'd1:    sel_byte = y;
      default: sel_byte = z;
    endcase
  endfunction

  assign cur_byte_s = sel_byte(idx_q, a_q, b_q, op_q);
  assign nxt_byte_s = sel_byte(idx_q + 2'd1, a_q, b_q, op_q);
  assign rx_fall_s  = rx_prev_q & ~rx_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= S_IDLE;
      tx_st_q   <= SER_IDLE;
      rx_st_q   <= SER_IDLE;
      a_q       <= {DBIT{1'b0}};
      b_q       <= {DBIT{1'b0}};
      op_q      <= {DBIT{1'b0}};
      idx_q     <= 2'd0;
      tx_cnt_q  <= {CW{1'b0}};
      rx_cnt_q  <= {CW{1'b0}};
      tx_bit_q  <= {BW{1'b0}};
      rx_bit_q  <= {BW{1'b0}};
      tx_sh_q   <= {DBIT{1'b0}};
      rx_sh_q   <= {DBIT{1'b0}};
      tx_q      <= 1'b1;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      to_q      <= {TW{1'b0}};
      result_q  <= {DBIT{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      terr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      tx_st_q   <= tx_st_d;
      rx_st_q   <= rx_st_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      rx_bit_q  <= rx_bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      tx_q      <= tx_d;
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      to_q      <= to_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      terr_q    <= terr_d;
      ferr_q    <= ferr_d;
    end
  end

  // Transmitter: the next frame is loaded straight from the stop bit so frames run back-to-back.
  always_comb begin
    tx_st_d        = tx_st_q;
    tx_cnt_d       = tx_cnt_q;
    tx_bit_d       = tx_bit_q;
    tx_sh_d        = tx_sh_q;
    tx_d           = tx_q;
    tx_frame_end_s = 1'b0;
    case (tx_st_q)
      SER_IDLE: begin
        tx_d = 1'b1;
        if ((st_q == S_SEND) && s_tick) begin
          tx_st_d  = SER_START;
          tx_cnt_d = {CW{1'b0}};
          tx_sh_d  = cur_byte_s;
          tx_d     = 1'b0;
        end else begin
          tx_st_d = SER_IDLE;
        end
      end
      SER_START: begin
        if (s_tick) begin
          if (tx_cnt_q == CW'(15)) begin
            tx_st_d  = SER_DATA;
            tx_cnt_d = {CW{1'b0}};
            tx_bit_d = {BW{1'b0}};
            tx_d     = tx_sh_q[0];
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q;
        end
      end
      SER_DATA: begin
        if (s_tick) begin
          if (tx_cnt_q == CW'(15)) begin
            tx_cnt_d = {CW{1'b0}};
            tx_sh_d  = tx_sh_q >> 1;
            if (tx_bit_q == BW'(DBIT - 1)) begin
              tx_st_d = SER_STOP;
              tx_d    = 1'b1;
            end else begin
              tx_bit_d = tx_bit_q + BW'(1);
              tx_d     = tx_sh_q[1];
            end
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q;
        end
      end
      SER_STOP: begin
        if (s_tick) begin
          if (tx_cnt_q == CW'(SB_TICK - 1)) begin
            tx_frame_end_s = 1'b1;
            tx_cnt_d       = {CW{1'b0}};
            if (idx_q == 2'd2) begin
              tx_st_d = SER_IDLE;
              tx_d    = 1'b1;
            end else begin
              tx_st_d = SER_START;
              tx_sh_d = nxt_byte_s;
              tx_d    = 1'b0;
            end
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q;
        end
      end
      default: begin
        tx_st_d = SER_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Receiver: held idle outside WAIT_RX so stray traffic during the request is dropped.
  always_comb begin
    rx_st_d         = rx_st_q;
    rx_cnt_d        = rx_cnt_q;
    rx_bit_d        = rx_bit_q;
    rx_sh_d         = rx_sh_q;
    rx_frame_done_s = 1'b0;
    if (st_q != S_WAIT) begin
      rx_st_d = SER_IDLE;
    end else begin
      case (rx_st_q)
        SER_IDLE: begin
          if (rx_fall_s) begin
            rx_st_d  = SER_START;
            rx_cnt_d = {CW{1'b0}};
          end else begin
            rx_st_d = SER_IDLE;
          end
        end
        SER_START: begin
          if (s_tick) begin
            if (rx_cnt_q == CW'(7)) begin
              rx_cnt_d = {CW{1'b0}};
              rx_bit_d = {BW{1'b0}};
              rx_st_d  = rx_sync_q ? SER_IDLE : SER_DATA;
            end else begin
              rx_cnt_d = rx_cnt_q + CW'(1);
            end
          end else begin
            rx_cnt_d = rx_cnt_q;
          end
        end
        SER_DATA: begin
          if (s_tick) begin
            if (rx_cnt_q == CW'(15)) begin
              rx_cnt_d = {CW{1'b0}};
              rx_sh_d  = {rx_sync_q, rx_sh_q[DBIT-1:1]};
              if (rx_bit_q == BW'(DBIT - 1)) begin
                rx_st_d = SER_STOP;
              end else begin
                rx_bit_d = rx_bit_q + BW'(1);
              end
            end else begin
              rx_cnt_d = rx_cnt_q + CW'(1);
            end
          end else begin
            rx_cnt_d = rx_cnt_q;
          end
        end
        SER_STOP: begin
          if (s_tick) begin
            if (rx_cnt_q == CW'(SB_TICK - 1)) begin
              rx_st_d         = SER_IDLE;
              rx_frame_done_s = 1'b1;
            end else begin
              rx_cnt_d = rx_cnt_q + CW'(1);
            end
          end else begin
            rx_cnt_d = rx_cnt_q;
          end
        end
        default: rx_st_d = SER_IDLE;
      endcase
    end
  end

  // Transaction sequencer; busy/done are derived from the next state so they line up with it.
  always_comb begin
    st_d     = st_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    to_d     = to_q;
    result_d = result_q;
    terr_d   = terr_q;
    ferr_d   = ferr_q;
    case (st_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          op_d   = DBIT'(op);
          idx_d  = 2'd0;
          terr_d = 1'b0;
          ferr_d = 1'b0;
          st_d   = S_SEND;
        end else begin
          st_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (tx_frame_end_s) begin
          if (idx_q == 2'd2) begin
            st_d = S_WAIT;
            to_d = {TW{1'b0}};
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          st_d = S_SEND;
        end
      end
      S_WAIT: begin
        if (rx_frame_done_s) begin
          result_d = rx_sh_q;
          ferr_d   = ~rx_sync_q;
          st_d     = S_DONE;
        end else if (s_tick && (rx_st_q == SER_IDLE)) begin
          if (to_q >= TW'(TIMEOUT_TICKS - 1)) begin
            result_d = {DBIT{1'b0}};
            terr_d   = 1'b1;
            st_d     = S_DONE;
          end else begin
            to_d = to_q + TW'(1);
          end
        end else begin
          st_d = S_WAIT;
        end
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    busy_d = (st_d == S_SEND) || (st_d == S_WAIT);
    done_d = (st_d == S_DONE);
  end

  assign tx          = tx_q;
  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_uart_alu_host.sv
// Scoreboard bench for uart_alu_host: a line-level UART decoder watches tx, a reply driver
// plays the device, and a done monitor checks each completion against queued expectations.
module tb_uart_alu_host;

  localparam int TO       = 1200;
  localparam int K_NORM   = 0;
  localparam int K_FERR   = 1;
  localparam int K_TO     = 2;
  localparam int K_GLITCH = 3;
  localparam int K_EARLY  = 4;
  localparam int K_SPAM   = 5;

  typedef struct {
    logic [7:0] data;
    int         start_cyc;
  } txe_t;

  typedef struct {
    logic [7:0] res;
    logic       terr;
    logic       ferr;
    int         cyc;
  } rese_t;

  logic       clk = 1'b0;
  logic       reset, s_tick, start, rx;
  logic [7:0] a, b;
  logic [5:0] op;
  logic       tx, busy, done, timeout_err, frame_err;
  logic [7:0] result;

  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0;
  txe_t  txq[$];
  rese_t resq[$];
  logic [7:0] last_res;
  logic       last_terr, last_ferr;

  uart_alu_host #(.DBIT(8), .SB_TICK(16), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .start(start), .a(a), .b(b), .op(op),
    .rx(rx), .tx(tx), .result(result), .busy(busy), .done(done),
    .timeout_err(timeout_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [7:0] alu(input logic [7:0] x, input logic [7:0] y, input logic [5:0] o);
    case (o)
      6'h20:   alu = x + y;
      6'h22:   alu = x - y;
      6'h24:   alu = x & y;
      6'h25:   alu = x | y;
      6'h26:   alu = x ^ y;
      default: alu = ~x;
    endcase
  endfunction

  // Line decoder on tx: samples mid-bit, checks framing and start time of every frame.
  initial begin
    bit         act;
    int         cnt, sc;
    logic [9:0] fr;
    txe_t       e;
    act = 1'b0;
    cnt = 0;
    sc  = 0;
    fr  = 10'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          cnt = 0;
          sc  = cyc;
          fr  = 10'd0;
        end
      end else begin
        cnt++;
        if (cnt >= 8 && cnt <= 152 && ((cnt - 8) % 16) == 0) fr[(cnt - 8) / 16] = tx;
        if (cnt == 159) begin
          act = 1'b0;
          if (txq.size() == 0) flag("tx_unexpected_frame");
          else begin
            e = txq.pop_front();
            chk("tx_frame", 32'(fr), 32'({1'b1, e.data, 1'b0}));
            chk("tx_frame_start", sc, e.start_cyc);
          end
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse.
  initial begin
    logic  done_prev;
    rese_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && done === 1'b1) begin
        done_cnt++;
        chk("done_single_cycle", 32'(done_prev), 32'd0);
        if (resq.size() == 0) flag("done_unexpected");
        else begin
          e = resq.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("timeout_err", 32'(timeout_err), 32'(e.terr));
          chk("frame_err", 32'(frame_err), 32'(e.ferr));
          chk("busy_at_done", 32'(busy), 32'd0);
          if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
        end
      end
      done_prev = done;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_ok;
    repeat (16) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_done(input int base, input int bound);
    int n;
    n = 0;
    while (done_cnt == base && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_cnt != base), 32'd1);
  endtask

  task automatic do_start(input logic [7:0] ta, input logic [7:0] tb_, input logic [5:0] top,
                          output int c);
    txe_t t;
    @(negedge clk);
    chk("result_held", 32'(result), 32'(last_res));
    chk("timeout_err_held", 32'(timeout_err), 32'(last_terr));
    chk("frame_err_held", 32'(frame_err), 32'(last_ferr));
    c = cyc;
    t.data = ta;            t.start_cyc = c + 2;   txq.push_back(t);
    t.data = tb_;           t.start_cyc = c + 162; txq.push_back(t);
    t.data = {2'b00, top};  t.start_cyc = c + 322; txq.push_back(t);
    a = ta; b = tb_; op = top; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 6'($urandom);
    chk("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic txn(input logic [7:0] ta, input logic [7:0] tb_, input logic [5:0] top,
                     input int kind, input logic [7:0] reply);
    int    c, base, d;
    rese_t e;
    do_start(ta, tb_, top, c);
    if (kind == K_EARLY) send_frame(8'h3C, 1'b1);
    if (kind == K_SPAM) begin
      for (int i = 0; i < 30; i++) begin
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      start = 1'b0;
    end
    while (cyc < c + 482) @(negedge clk);
    base = done_cnt;
    if (kind == K_GLITCH) begin
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_no_done", done_cnt, base);
    end
    d = $urandom_range(0, 30);
    repeat (d) @(negedge clk);
    if (kind == K_TO) begin
      e.res = 8'h00; e.terr = 1'b1; e.ferr = 1'b0; e.cyc = c + 482 + TO;
      resq.push_back(e);
      wait_done(base, TO + 200);
    end else begin
      e.res = reply; e.terr = 1'b0; e.ferr = (kind == K_FERR); e.cyc = -1;
      resq.push_back(e);
      send_frame(reply, kind != K_FERR);
      wait_done(base, 200);
    end
    last_res = e.res; last_terr = e.terr; last_ferr = e.ferr;
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic reset_test();
    int c;
    do_start(8'($urandom), 8'($urandom), 6'h20, c);
    while (cyc < c + 2 + 160 + 16 + 40) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_tx_high", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    repeat (3) @(negedge clk);
    txq.delete();
    last_res = 8'h00; last_terr = 1'b0; last_ferr = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] ops[5];
    int         kinds[5];
    logic [7:0] ra, rb;
    logic [5:0] ro;
    int         k;
    ops   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
    kinds = '{K_NORM, K_FERR, K_GLITCH, K_EARLY, K_SPAM};
    reset = 1'b1; s_tick = 1'b1; start = 1'b0; rx = 1'b1;
    a = 8'h00; b = 8'h00; op = 6'h00;
    last_res = 8'h00; last_terr = 1'b0; last_ferr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    txn(8'h05, 8'h03, 6'h20, K_NORM, 8'h08);
    txn(8'h05, 8'h03, 6'h20, K_TO, 8'h00);
    txn(8'h12, 8'h34, 6'h25, K_FERR, 8'hA5);
    ra = 8'($urandom); rb = 8'($urandom);
    txn(ra, rb, 6'h24, K_GLITCH, alu(ra, rb, 6'h24));
    txn(8'h40, 8'h02, 6'h22, K_EARLY, 8'h11);
    ra = 8'($urandom); rb = 8'($urandom);
    txn(ra, rb, 6'h26, K_SPAM, alu(ra, rb, 6'h26));
    txn(8'hFF, 8'h01, 6'h22, K_NORM, alu(8'hFF, 8'h01, 6'h22));
    txn(8'h05, 8'h03, 6'h20, K_NORM, 8'h08);
    reset_test();
    txn(8'h21, 8'h10, 6'h20, K_NORM, alu(8'h21, 8'h10, 6'h20));
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ro = ops[$urandom_range(0, 4)];
      k  = kinds[$urandom_range(0, 4)];
      txn(ra, rb, ro, k, alu(ra, rb, ro));
    end
    repeat (5) @(negedge clk);
    chk("tx_queue_drained", txq.size(), 0);
    chk("res_queue_drained", resq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its cycle budget (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/uart_alu_host.md
# uart_alu_host

Host-side initiator for the UART ALU link: takes an operand pair and opcode, serializes them as three 8N1 UART frames (A, B, op), then waits for the single result frame returned by the UART ALU device and presents it with a done pulse. It contains its own 16x-oversampled transmitter and receiver, driven by the shared baud-rate tick. It serves as the bench/master counterpart of the device and can be instantiated on a second FPGA or in loopback tests.

## Interface

- DBIT, 8, data bits per frame
- SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop bit)
- TIMEOUT_TICKS, 65535, s_ticks allowed between end of last sent stop bit and start bit of the reply
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- s_tick  in  1  one-cycle pulse at 16x baud rate, from the baud-rate generator
- start  in  1  request a transaction; sampled only in IDLE
- a  in  DBIT  operand A, latched on accepted start
- b  in  DBIT  operand B, latched on accepted start
- op  in  6  ALU opcode, latched on accepted start
- rx  in  1  serial input from device tx (idle high)
- tx  out  1  serial output to device rx (idle high)
- result  out  DBIT  last received result byte
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- timeout_err  out  1  last transaction ended by timeout
- frame_err  out  1  last reply had stop bit sampled low

## Operation

- Top FSM: IDLE, SEND, WAIT_RX, DONE.
- IDLE: start=1 latches a, b, {2'b00, op}; byte index := 0; clears timeout_err, frame_err; -> SEND.
- SEND: transmits byte[index] (order A, B, op byte); on each frame end index++; after third stop bit -> WAIT_RX, timeout counter := 0.
- WAIT_RX: receiver enabled; valid frame -> result := byte, frame_err := 0, -> DONE. Frame with stop bit low -> result := byte, frame_err := 1, -> DONE. Timeout counter increments per s_tick while no start bit in progress; reaching TIMEOUT_TICKS -> result := 0, timeout_err := 1, -> DONE.
- DONE: done=1 for exactly one cycle, -> IDLE.
- Transmitter sub-FSM: idle, start, data, stop. Start bit 16 ticks low, DBIT data bits LSB first 16 ticks each, stop bit SB_TICK ticks high. Frames sent back-to-back, no idle gap.
- Receiver sub-FSM: idle, start, data, stop. Falling edge of rx in idle -> start; at tick 7 rx still low confirms start (else back to idle, glitch ignored); then samples each data bit at 16-tick intervals (mid-bit); stop sampled after SB_TICK ticks.
- Receiver frames completed outside WAIT_RX are discarded; receiver runs only in WAIT_RX.
- start while busy ignored. result, timeout_err, frame_err held until next accepted start.

## Timing

- Reset values: tx=1, busy=0, done=0, result=0, timeout_err=0, frame_err=0; FSMs in idle. Reset mid-frame forces tx=1 immediately (asynchronously).
- busy rises the cycle after start is accepted; falls in the same cycle done pulses.
- tx goes low on the first s_tick after start acceptance; one frame = (1+DBIT)*16+SB_TICK ticks = 160 ticks at defaults; request phase = 480 ticks.
- done asserts on the cycle after the reply stop-bit sample (or timeout count reached).
- start asserted in DONE cycle is ignored; accepted in the following IDLE cycle at earliest.
- Timeout counter is TIMEOUT_TICKS-wide enough (16 bits at default); it saturates, never wraps.

## Test plan

- Basic add: s_tick every cycle, a=8'h05, b=8'h03, op=6'b100000, start pulse; check tx frames 8'h05, 8'h03, 8'h20, LSB first, 160 ticks each; model replies 8'h08 -> result=8'h08, done one cycle, busy then 0, errors 0.
- Timeout: same request, no reply -> done exactly TIMEOUT_TICKS ticks after last stop bit, timeout_err=1, result=8'h00.
- Framing error: reply 8'hA5 with stop bit driven low -> result=8'hA5, frame_err=1, done pulses.
- Glitch/early traffic: 3-tick low pulse on rx in WAIT_RX -> ignored, no done; full frame 8'h3C on rx during SEND -> discarded, later reply 8'h11 gives result=8'h11.
- Busy/start: start pulsed repeatedly during SEND -> no extra frames; second transaction after done with a=8'hFF, b=8'h01, op=6'h22 sends 8'hFF, 8'h01, 8'h22.
- Reset mid-op: assert reset during data bit of byte B -> tx=1 same cycle, busy=0, result=0; after release, new start sends a full 3-frame request.
